// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants, FSM state type and helpers for the PS/2 key
// receiver.
//   - Set-2 prefix bytes (E0 extended, F0 release, E1 pause).
//   - Device response bytes, which are ignored when no prefix is pending.
//   - Frame FSM state enum.
//   - Helper that converts CLK_HZ / TIMEOUT_US into a cycle count.
package ps2_pkg;

    localparam logic [7:0] BYTE_E0 = 8'hE0;
    localparam logic [7:0] BYTE_F0 = 8'hF0;
    localparam logic [7:0] BYTE_E1 = 8'hE1;

    // The E1 prefix is followed by 7 more Pause bytes, which are all swallowed.
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_t;

    function automatic int timeout_cycles(input int clk_hz, input int timeout_us);
        return (clk_hz / 1_000_000) * timeout_us;
    endfunction

    // Keyboard responses: ACK, BAT ok, echo, BAT fail, resend, error codes.
    function automatic logic is_response(input logic [7:0] b);
        case (b)
            8'hFA, 8'hAA, 8'hEE, 8'hFC, 8'hFE, 8'h00, 8'hFF: return 1'b1;
            default:                                         return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: brings one raw PS/2 line into the clk domain and debounces it.
// It uses a 2-FF synchroniser followed by a run-length filter. The output
// follows the synchronised line only after FILTER_LEN consecutive samples
// that differ from the current output. Raw-to-filtered latency is
// 2 + FILTER_LEN cycles. Everything resets to 1, because an idle line is high.
// Ports:
//   clk, rst_n  system clock, async active-low reset
//   line_in     raw asynchronous line
//   line_out    synchronised, filtered line
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line_in,
    output logic line_out
);

    localparam int CNT_W = $clog2(FILTER_LEN);

    logic             sync_q1;
    logic             sync_q2;
    logic [CNT_W-1:0] run_cnt;

    // NOTE: every register in a clocked block is assigned with <=, so all
    // reads see the values from before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1  <= 1'b1;
            sync_q2  <= 1'b1;
            run_cnt  <= '0;
            line_out <= 1'b1;
        end else begin
            sync_q1 <= line_in;
            sync_q2 <= sync_q1;
            if (sync_q2 == line_out) begin
                run_cnt <= '0;
            end else if (run_cnt == CNT_W'(FILTER_LEN - 1)) begin
                // This is the FILTER_LEN-th differing sample in a row.
                line_out <= sync_q2;
                run_cnt  <= '0;
            end else begin
                run_cnt <= run_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_key_receiver.sv
// ps2_key_receiver: turns the PS/2 keyboard line into 11-bit key event words.
// Ports:
//   clk, rst_n    system clock, async active-low reset
//   ps2_clk_in    raw PS/2 clock (device driven, asynchronous)
//   ps2_data_in   raw PS/2 data  (device driven, asynchronous)
//   ps2_key       {toggle, press, extended, scancode}; bit 10 flips per event
//   frame_error   one-cycle pulse on a parity/start/stop/timeout failure
//   busy          high while a frame is being received
module ps2_key_receiver
    import ps2_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT_US = 200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ps2_clk_in,
    input  logic        ps2_data_in,
    output logic [10:0] ps2_key,
    output logic        frame_error,
    output logic        busy
);

    localparam int TMO_CYCLES = timeout_cycles(CLK_HZ, TIMEOUT_US);
    localparam int TMO_W      = $clog2(TMO_CYCLES) + 1;

    logic             clk_f, data_f, clk_f_q, fall;
    ps2_state_t       state, state_next;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift_q;
    logic             parity_q;
    logic [TMO_W-1:0] tmo_cnt;
    logic             timeout, byte_ok, frame_bad;
    logic             ext_q, rel_q;
    logic [2:0]       skip_q;
    logic [10:0]      key_q;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk      (clk),
        .rst_n    (rst_n),
        .line_in  (ps2_clk_in),
        .line_out (clk_f)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clk      (clk),
        .rst_n    (rst_n),
        .line_in  (ps2_data_in),
        .line_out (data_f)
    );

    assign fall = clk_f_q & ~clk_f;

    // A falling edge in the same cycle as expiry wins. The counter reloads
    // on that edge instead of expiring.
    assign timeout = (state != IDLE) && (tmo_cnt == '0) && !fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: every output of this block gets a default value first, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        byte_ok    = 1'b0;
        frame_bad  = 1'b0;
        case (state)
            IDLE:   if (fall && !data_f) state_next = DATA;
            DATA:   if (fall && bit_cnt == 3'd7) state_next = PARITY;
            PARITY: if (fall) state_next = STOP;
            STOP: begin
                if (fall) begin
                    state_next = IDLE;
                    if (data_f && (^{parity_q, shift_q})) byte_ok   = 1'b1;
                    else                                  frame_bad = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        if (timeout) begin
            state_next = IDLE;
            frame_bad  = 1'b1;
        end
    end

    // Frame datapath: bit shifter, parity capture, timeout counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_f_q  <= 1'b1;
            bit_cnt  <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            tmo_cnt  <= '0;
        end else begin
            clk_f_q <= clk_f;
            if (fall) begin
                case (state)
                    IDLE:   bit_cnt <= '0;
                    DATA: begin
                        shift_q <= {data_f, shift_q[7:1]};  // LSB arrives first
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    PARITY: parity_q <= data_f;
                    default: ;
                endcase
            end
            if (state_next == IDLE) tmo_cnt <= '0;
            else if (fall)          tmo_cnt <= TMO_W'(TMO_CYCLES);
            else if (tmo_cnt != '0) tmo_cnt <= tmo_cnt - TMO_W'(1);
        end
    end

    // Byte handler. It only sees bytes with a good frame. A frame error
    // drops any prefix in flight, so a broken sequence cannot produce an event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_q       <= 1'b0;
            rel_q       <= 1'b0;
            skip_q      <= '0;
            key_q       <= '0;
            frame_error <= 1'b0;
        end else begin
            frame_error <= frame_bad;
            if (frame_bad) begin
                ext_q  <= 1'b0;
                rel_q  <= 1'b0;
                skip_q <= '0;
            end else if (byte_ok) begin
                if (skip_q != '0) begin
                    skip_q <= skip_q - 3'd1;
                end else if (shift_q == BYTE_E1) begin
                    skip_q <= PAUSE_SKIP;
                end else if (shift_q == BYTE_E0) begin
                    ext_q <= 1'b1;
                end else if (shift_q == BYTE_F0) begin
                    rel_q <= 1'b1;
                end else if (is_response(shift_q) && !ext_q && !rel_q) begin
                    // Keyboard response byte; no key event.
                end else begin
                    key_q <= {~key_q[10], ~rel_q, ext_q, shift_q};
                    ext_q <= 1'b0;
                    rel_q <= 1'b0;
                end
            end
        end
    end

    assign ps2_key = key_q;
    assign busy    = (state != IDLE);

endmodule

// File: tb/tb_ps2_key_receiver.sv
`timescale 1ns/1ps
module tb_ps2_key_receiver;

    // A 2 MHz system clock keeps the cycle count low while the PS/2 clock
    // still runs at a real 12.5 kHz (80 us period).
    localparam int CLK_HZ     = 2_000_000;
    localparam int FILTER_LEN = 8;
    localparam int TIMEOUT_US = 200;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ps2_clk_in = 1'b1;
    logic        ps2_data_in = 1'b1;
    logic [10:0] ps2_key;
    logic        frame_error;
    logic        busy;

    ps2_key_receiver #(
        .CLK_HZ     (CLK_HZ),
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT_US (TIMEOUT_US)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_key     (ps2_key),
        .frame_error (frame_error),
        .busy        (busy)
    );

    always #250 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: the scancode protocol rules, kept at byte level.
    logic [10:0] exp_q[$];
    logic        m_ext = 1'b0;
    logic        m_rel = 1'b0;
    int          m_skip = 0;
    logic        m_toggle = 1'b0;
    int          exp_evt_cnt = 0;
    int          exp_err_cnt = 0;
    int          seen_evt_cnt = 0;
    int          seen_err_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic resp_byte(input logic [7:0] b);
        return (b == 8'hFA) || (b == 8'hAA) || (b == 8'hEE) || (b == 8'hFC) ||
               (b == 8'hFE) || (b == 8'h00) || (b == 8'hFF);
    endfunction

    task automatic model_byte(input logic [7:0] b);
        if (m_skip > 0) begin
            m_skip--;
        end else if (b == 8'hE1) begin
            m_skip = 7;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_rel = 1'b1;
        end else if (!(resp_byte(b) && !m_ext && !m_rel)) begin
            m_toggle = ~m_toggle;
            exp_q.push_back({m_toggle, ~m_rel, m_ext, b});
            exp_evt_cnt++;
            m_ext = 1'b0;
            m_rel = 1'b0;
        end
    endtask

    task automatic model_error();
        m_ext  = 1'b0;
        m_rel  = 1'b0;
        m_skip = 0;
        exp_err_cnt++;
    endtask

    // Data changes in the middle of the clock-high phase, as a device would drive it.
    task automatic drive_bit(input logic b);
        ps2_data_in = b;
        #20_000;
        ps2_clk_in = 1'b0;
        #40_000;
        ps2_clk_in = 1'b1;
        #20_000;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_parity);
        if (bad_parity) model_error();
        else            model_byte(b);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(bad_parity ? (^b) : ~(^b));
        drive_bit(1'b1);
        ps2_data_in = 1'b1;
        #30_000;
    endtask

    task automatic send_good(input logic [7:0] b);
        send_frame(b, 1'b0);
    endtask

    // Monitor: it compares every change of ps2_key against the scoreboard
    // and checks that each frame_error pulse lasts exactly one cycle.
    initial begin : monitor
        logic [10:0] prev_key;
        logic [10:0] exp_word;
        logic        fe_prev;
        prev_key = '0;
        fe_prev  = 1'b0;
        @(posedge rst_n);
        forever begin
            @(negedge clk);
            if (ps2_key !== prev_key) begin
                seen_evt_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_event", 32'(ps2_key), 32'(prev_key));
                end else begin
                    exp_word = exp_q.pop_front();
                    check("event_word", 32'(ps2_key), 32'(exp_word));
                end
                prev_key = ps2_key;
            end
            if (fe_prev) check("frame_error_width", 32'(frame_error), 32'd0);
            if (frame_error && !fe_prev) seen_err_cnt++;
            fe_prev = frame_error;
        end
    end

    initial begin : watchdog
        #80_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [7:0] rb;
        repeat (5) @(posedge clk);
        #1;
        check("reset_key", 32'(ps2_key), 32'd0);
        check("reset_frame_error", 32'(frame_error), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);

        // A key: press event, toggle bit goes 0 -> 1.
        send_good(8'h1C);
        check("a_press_word", 32'(ps2_key), 32'h61C);

        // A release.
        send_good(8'hF0);
        send_good(8'h1C);
        check("a_release_word", 32'(ps2_key), 32'h01C);

        // Extended release, then a plain press must not carry the extended bit.
        send_good(8'hE0);
        send_good(8'hF0);
        send_good(8'h75);
        check("ext_release_word", 32'(ps2_key), 32'h575);
        send_good(8'h1C);

        // A frame with bad parity is rejected; a valid F0 1C follows.
        send_frame(8'h1C, 1'b1);
        send_good(8'hF0);
        send_good(8'h1C);

        // Pause sequence: no events. A normal press follows.
        send_good(8'hE1); send_good(8'h14); send_good(8'h77); send_good(8'hE1);
        send_good(8'hF0); send_good(8'h14); send_good(8'hF0); send_good(8'h77);
        send_good(8'h1C);

        // Timeout with an E0 pending: the frame is lost and the prefix is dropped.
        send_good(8'hE0);
        model_error();
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        ps2_data_in = 1'b1;
        check("busy_mid_frame", 32'(busy), 32'd1);
        #300_000;
        check("busy_after_timeout", 32'(busy), 32'd0);
        send_good(8'h1C);

        // A one-cycle glitch on the idle clock line must be filtered out.
        @(posedge clk);
        ps2_clk_in = 1'b0;
        @(posedge clk);
        ps2_clk_in = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("busy_after_glitch", 32'(busy), 32'd0);
        send_good(8'h2B);

        // Randomised stream with prefixes, responses, bad frames and random codes.
        for (int n = 0; n < 10; n++) begin
            case ($urandom_range(0, 7))
                0: send_good(8'hE0);
                1: send_good(8'hF0);
                2: send_good(8'hFA);
                3: send_frame(8'($urandom), 1'b1);
                default: begin
                    rb = 8'($urandom);
                    send_good(rb);
                end
            endcase
        end

        #200_000;
        check("pending_expected", 32'(exp_q.size()), 32'd0);
        check("event_count", 32'(seen_evt_cnt), 32'(exp_evt_cnt));
        check("frame_error_count", 32'(seen_err_cnt), 32'(exp_err_cnt));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
